io_led_sequencer: RTL and testbench



---
 rtl/io_led_sequencer.sv | 127 ++++++++++++
 tb/tb_io_led_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/io_led_sequencer.sv
// LED / differential-output pattern sequencer: a prescaled FSM drives the OBUF
// and OBUFTDS I/T pins with a binary-count, walking-one, blink or hold pattern.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | outputs quiet, prescaler and pattern cleared, waiting for en
// ST_ARM   | prescaler running, pair still high-Z; first tick loads pattern
// ST_RUN   | pattern advances on every tick, differential pair driven
module io_led_sequencer #(
  parameter int LOG2DELAY = 25,
  parameter int WIDTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             diff_i,
  output logic             diff_t,
  output logic             tick
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [LOG2DELAY-1:0] PRESC_MAX = '1;
  localparam logic [WIDTH-1:0]     PAT_ONES  = '1;
  localparam logic [WIDTH-1:0]     PAT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [LOG2DELAY-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]     pat_q, pat_d;
  logic [1:0]           mode_q, mode_d;
  logic [WIDTH-1:0]     led_q, led_d;
  logic                 diff_i_q, diff_i_d;
  logic                 diff_t_q, diff_t_d;
  logic                 tick_q, tick_d;

  function automatic logic [WIDTH-1:0] pat_init(input logic [1:0] m);
    case (m)
      2'd1:    pat_init = PAT_ONE;
      2'd2:    pat_init = PAT_ONES;
      default: pat_init = '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pat_next(input logic [WIDTH-1:0] p,
                                                input logic [1:0]       m);
    logic one_hot;
    one_hot = (p != '0) && ((p & (p - 1'b1)) == '0);
    case (m)
      2'd0:    pat_next = p + 1'b1;
      2'd1:    pat_next = one_hot ? {p[WIDTH-2:0], p[WIDTH-1]} : PAT_ONE;
      2'd2:    pat_next = ((p == '0) || (p == PAT_ONES)) ? ~p : PAT_ONES;
      default: pat_next = p;
    endcase
  endfunction

  // tick_q is asserted exactly while presc_q == PRESC_MAX outside IDLE,
  // so it doubles as the internal tick condition.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        pat_d   = '0;
        if (en) state_d = ST_ARM;
      end
      ST_ARM, ST_RUN: begin
        if (!en) begin
          state_d = ST_IDLE;
          presc_d = '0;
          pat_d   = '0;
        end else begin
          presc_d = presc_q + 1'b1;
          if (tick_q) begin
            mode_d  = mode;
            state_d = ST_RUN;
            pat_d   = (state_q == ST_ARM) ? pat_init(mode_d) : pat_next(pat_q, mode_d);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
        pat_d   = '0;
      end
    endcase

    tick_d   = (state_d != ST_IDLE) && (presc_d == PRESC_MAX);
    led_d    = (state_d == ST_RUN) ? pat_d : '0;
    diff_i_d = led_d[0];
    diff_t_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      pat_q    <= '0;
      mode_q   <= 2'd0;
      led_q    <= '0;
      diff_i_q <= 1'b0;
      diff_t_q <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      pat_q    <= pat_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      diff_i_q <= diff_i_d;
      diff_t_q <= diff_t_d;
      tick_q   <= tick_d;
    end
  end

  assign led    = led_q;
  assign diff_i = diff_i_q;
  assign diff_t = diff_t_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_io_led_sequencer.sv
// Self-checking bench for io_led_sequencer with a 4-clock tick period; expected
// LED values are queued as stimulus is applied and popped after each tick.
module tb_io_led_sequencer;
  localparam int L      = 2;
  localparam int W      = 4;
  localparam int PERIOD = 1 << L;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [1:0]   mode;
  logic [W-1:0] led;
  logic         diff_i, diff_t, tick;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  int           n;
  int           tick_cnt;

  io_led_sequencer #(.LOG2DELAY(L), .WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .led    (led),
    .diff_i (diff_i),
    .diff_t (diff_t),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_tick(input string tag);
    for (int i = 0; i < 4 * PERIOD; i++) begin
      @(negedge clk);
      if (tick) break;
    end
    chk({tag, "_tick_seen"}, 32'(tick), 32'd1);
  endtask

  task automatic check_out(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_underflow"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_led"}, 32'(led), 32'(e));
      chk({tag, "_diff_i"}, 32'(diff_i), 32'(e[0]));
      chk({tag, "_diff_t"}, 32'(diff_t), 32'd0);
    end
  endtask

  task automatic expect_ticks(input int cnt, input string tag);
    for (int k = 0; k < cnt; k++) begin
      wait_tick(tag);
      @(negedge clk);
      check_out(tag);
    end
  endtask

  task automatic measure_tick(output int cycles);
    cycles = 0;
    for (int i = 0; i < 8 * PERIOD; i++) begin
      @(negedge clk);
      cycles++;
      if (tick) break;
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'd1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_diff_t", 32'(diff_t), 32'd1);
      chk("rst_tick", 32'(tick), 32'd0);
    end

    rst  = 1'b0;
    mode = 2'd0;
    measure_tick(n);
    chk("arm_latency", 32'(n), 32'(PERIOD));
    chk("arm_led", 32'(led), 32'd0);
    chk("arm_diff_t", 32'(diff_t), 32'd1);
    exp_q.push_back(4'h0);
    @(negedge clk);
    check_out("run_entry");

    for (int i = 1; i <= 19; i++) exp_q.push_back(4'(i % 16));
    expect_ticks(19, "count");

    mode = 2'd1;
    exp_q.push_back(4'h1); exp_q.push_back(4'h2); exp_q.push_back(4'h4);
    exp_q.push_back(4'h8); exp_q.push_back(4'h1);
    expect_ticks(5, "walk");

    mode = 2'd2;
    exp_q.push_back(4'hF); exp_q.push_back(4'h0); exp_q.push_back(4'hF);
    expect_ticks(3, "blink");

    @(negedge clk);
    mode = 2'd3;
    @(negedge clk);
    chk("hold_pre_tick_led", 32'(led), 32'hF);
    exp_q.push_back(4'hF); exp_q.push_back(4'hF);
    expect_ticks(2, "hold");

    mode = 2'd0;
    for (int i = 0; i <= 5; i++) exp_q.push_back(4'(i));
    expect_ticks(6, "count2");

    wait_tick("dis");
    chk("dis_tick_led", 32'(led), 32'h5);
    en = 1'b0;
    @(negedge clk);
    chk("dis_led", 32'(led), 32'd0);
    chk("dis_diff_i", 32'(diff_i), 32'd0);
    chk("dis_diff_t", 32'(diff_t), 32'd1);

    en   = 1'b1;
    mode = 2'd1;
    n    = 0;
    for (int i = 0; i < 8 * PERIOD; i++) begin
      @(negedge clk);
      n++;
      if (!diff_t) break;
    end
    chk("rearm_latency", 32'(n), 32'(PERIOD + 1));
    chk("rearm_led", 32'(led), 32'h1);
    exp_q.push_back(4'h2); exp_q.push_back(4'h4);
    exp_q.push_back(4'h8); exp_q.push_back(4'h1);
    expect_ticks(4, "walk2");

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_led", 32'(led), 32'd0);
    chk("mrst_diff_i", 32'(diff_i), 32'd0);
    chk("mrst_diff_t", 32'(diff_t), 32'd1);
    chk("mrst_tick", 32'(tick), 32'd0);

    rst = 1'b0;
    en  = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (tick) tick_cnt++;
    end
    chk("idle_no_tick", 32'(tick_cnt), 32'd0);

    en = 1'b1;
    measure_tick(n);
    chk("post_rst_arm_latency", 32'(n), 32'(PERIOD));
    chk("post_rst_diff_t", 32'(diff_t), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
